// File: rtl/qspi_apb_host_bridge_if.sv
// rtl/qspi_apb_host_bridge_if.sv - APB-side bus bundle for the QSPI host bridge
interface qspi_apb_host_bridge_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/qspi_apb_host_bridge.sv
// rtl/qspi_apb_host_bridge.sv - APB completer tunnelling 16-bit accesses over quad SPI
// Optional QSPI_HOST_XFER_COUNT_EN adds a saturating completed-transfer counter port.
module qspi_apb_host_bridge #(
  parameter int CLK_DIV    = 2,
  parameter int READ_DUMMY = 4,
  parameter int CS_IDLE    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  qspi_apb_host_bridge_if.slave apb,
  output logic                  qspi_sck,
  output logic                  qspi_cs_n,
  inout  wire  [3:0]            qspi_dq
`ifdef QSPI_HOST_XFER_COUNT_EN
  ,
  output logic [31:0]           xfer_count
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_WDATA, S_DUMMY, S_RDATA, S_HOLD, S_DONE, S_GAP, S_ERR
  } state_t;

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int IW = $clog2(CS_IDLE + 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_FULL = DW'(CLK_DIV);
  localparam logic [IW-1:0] IDLE_MAX = IW'(CS_IDLE);
  localparam logic [7:0] CYC_CMD_LAST = 8'd7;
  localparam logic [7:0] CYC_WR_LAST  = 8'd11;
  localparam logic [7:0] CYC_DUM_LAST = 8'(8 + READ_DUMMY - 1);
  localparam logic [7:0] CYC_RD_LAST  = 8'(8 + READ_DUMMY + 3);
  localparam logic [7:0] OP_RD = 8'h40;
  localparam logic [7:0] OP_WR = 8'h41;

  state_t          state, state_nx;
  logic [DW-1:0]   div_cnt;
  logic            sck_ph;
  logic [7:0]      cyc_cnt;
  logic [47:0]     tx_sr;
  logic [15:0]     rx_sr;
  logic [15:0]     rx_cap;
  logic            is_write;
  logic [15:0]     prdata_q;
  logic [IW-1:0]   idle_cnt;
  logic [IW:0]     idle_run;
  logic            idle_ok;
  logic            legal;
  logic            req;
  logic            shift_st;
  logic            half_end;
  logic            sck_fall;
  logic            dq_oe;
  logic [3:0]      dq_o;

  assign legal    = !apb.paddr[0] && !apb.paddr[15];
  assign req      = apb.psel && apb.penable;
  assign shift_st = (state == S_CMD) || (state == S_WDATA) ||
                    (state == S_DUMMY) || (state == S_RDATA);
  assign half_end = (div_cnt == DIV_LAST);
  assign sck_fall = shift_st && sck_ph && half_end;
  assign rx_cap   = {rx_sr[11:0], qspi_dq};
  // idle_cnt counts completed cs_n-high clocks; the current clock counts too
  assign idle_run = {1'b0, idle_cnt} + {{IW{1'b0}}, 1'b1};
  assign idle_ok  = (idle_run >= {1'b0, IDLE_MAX});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req && !legal)          state_nx = S_ERR;
        else if (req && idle_ok)    state_nx = S_CMD;
      end
      S_CMD: begin
        if (sck_fall && cyc_cnt == CYC_CMD_LAST) begin
          if (is_write)             state_nx = S_WDATA;
          else if (READ_DUMMY == 0) state_nx = S_RDATA;
          else                      state_nx = S_DUMMY;
        end
      end
      S_WDATA: if (sck_fall && cyc_cnt == CYC_WR_LAST)  state_nx = S_HOLD;
      S_DUMMY: if (sck_fall && cyc_cnt == CYC_DUM_LAST) state_nx = S_RDATA;
      S_RDATA: if (sck_fall && cyc_cnt == CYC_RD_LAST)  state_nx = S_HOLD;
      S_HOLD:  if (div_cnt == DIV_FULL)                 state_nx = S_DONE;
      S_DONE:  state_nx = S_GAP;
      S_GAP:   state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    qspi_sck    = shift_st && sck_ph;
    qspi_cs_n   = !(shift_st || (state == S_HOLD && div_cnt != DIV_FULL));
    dq_oe       = (state == S_CMD) || (state == S_WDATA);
    dq_o        = tx_sr[47:44];
    apb.pready  = (state == S_DONE) || (state == S_ERR);
    apb.pslverr = (state == S_ERR);
  end

  assign apb.prdata = prdata_q;
  assign qspi_dq    = dq_oe ? dq_o : 4'bzzzz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      sck_ph   <= 1'b0;
      cyc_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      is_write <= 1'b0;
      prdata_q <= '0;
    end else if (state == S_IDLE) begin
      if (req && (!legal || idle_ok)) prdata_q <= '0;
      if (req && legal && idle_ok) begin
        tx_sr    <= {(apb.pwrite ? OP_WR : OP_RD), 8'h00, apb.paddr,
                     apb.pwdata[7:0], apb.pwdata[15:8]};
        is_write <= apb.pwrite;
        div_cnt  <= '0;
        sck_ph   <= 1'b0;
        cyc_cnt  <= '0;
      end
    end else if (shift_st) begin
      if (half_end) begin
        div_cnt <= '0;
        sck_ph  <= !sck_ph;
        if (sck_ph) begin
          cyc_cnt <= cyc_cnt + 8'd1;
          tx_sr   <= {tx_sr[43:0], 4'h0};
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      // read nibbles are taken on the last clk of each sck-high phase
      if (state == S_RDATA && sck_ph && half_end) begin
        rx_sr <= rx_cap;
        if (cyc_cnt == CYC_RD_LAST) prdata_q <= {rx_cap[7:0], rx_cap[15:8]};
      end
    end else if (state == S_HOLD) begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   idle_cnt <= IDLE_MAX;
    else if (!qspi_cs_n)          idle_cnt <= '0;
    else if (idle_cnt < IDLE_MAX) idle_cnt <= idle_cnt + IW'(1);
  end

`ifdef QSPI_HOST_XFER_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   xfer_count <= '0;
    else if (state == S_DONE && xfer_count != '1) xfer_count <= xfer_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_qspi_apb_host_bridge.sv
// tb/tb_qspi_apb_host_bridge.sv - randomized self-checking bench with a remote-device model
module tb_qspi_apb_host_bridge;
  localparam int CLK_DIV    = 2;
  localparam int READ_DUMMY = 4;
  localparam int CS_IDLE    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qspi_apb_host_bridge_if apb ();
  wire       qspi_sck;
  wire       qspi_cs_n;
  wire [3:0] qspi_dq;
  logic      dev_oe  = 1'b0;
  logic [3:0] dev_out = 4'h0;
  assign qspi_dq = dev_oe ? dev_out : 4'bzzzz;

`ifdef QSPI_HOST_XFER_COUNT_EN
  wire [31:0] xfer_count;
`endif

  qspi_apb_host_bridge #(
    .CLK_DIV(CLK_DIV), .READ_DUMMY(READ_DUMMY), .CS_IDLE(CS_IDLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .apb       (apb),
    .qspi_sck  (qspi_sck),
    .qspi_cs_n (qspi_cs_n),
    .qspi_dq   (qspi_dq)
`ifdef QSPI_HOST_XFER_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] dev_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  logic [3:0]  nib_q [$];
  int          cs_falls = 0;
  int          high_cnt = 1000;
  int          dev_fall = 0;
  bit          dev_rd   = 1'b0;
  logic [15:0] dev_addr = '0;
  int          exp_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dev_word(input logic [15:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : (a ^ 16'hA5A5);
  endfunction

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'hA5A5);
  endfunction

  function automatic logic [3:0] resp_nib(input logic [15:0] w, input int k);
    logic [15:0] s;
    s = {w[7:0], w[15:8]};
    return s[15-4*k -: 4];
  endfunction

  function automatic logic [63:0] nib_pack(input int first, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++)
      v = {v[59:0], (first + i < nib_q.size()) ? nib_q[first + i] : 4'hx};
    return v;
  endfunction

  always @(posedge clk) begin
    if (qspi_cs_n) high_cnt = high_cnt + 1;
    else           high_cnt = 0;
  end

  always @(negedge qspi_cs_n) begin
    check("cs_gap_ok", high_cnt >= CS_IDLE, 1);
    nib_q.delete();
    cs_falls++;
    dev_fall = 0;
    dev_rd   = 1'b0;
  end

  always @(posedge qspi_cs_n) dev_oe = 1'b0;

  always @(posedge qspi_sck) if (!qspi_cs_n) nib_q.push_back(qspi_dq);

  // remote device: decode the command, store writes, answer reads after the dummy cycles
  always @(negedge qspi_sck) begin
    if (!qspi_cs_n) begin
      dev_fall++;
      if (dev_fall == 8) begin
        dev_rd   = ({nib_q[0], nib_q[1]} == 8'h40);
        dev_addr = {nib_q[4], nib_q[5], nib_q[6], nib_q[7]};
      end
      if (dev_fall == 12 && {nib_q[0], nib_q[1]} == 8'h41)
        dev_mem[dev_addr] = {nib_q[10], nib_q[11], nib_q[8], nib_q[9]};
      if (dev_rd && dev_fall >= 8 + READ_DUMMY && dev_fall < 12 + READ_DUMMY) begin
        #1;
        dev_out = resp_nib(dev_word(dev_addr), dev_fall - 8 - READ_DUMMY);
        dev_oe  = 1'b1;
      end else if (dev_rd && dev_fall == 12 + READ_DUMMY) begin
        #1;
        dev_oe = 1'b0;
      end
    end
  end

  task automatic apb_xfer(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                          output logic [15:0] rd, output bit err, output int lat);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = wd;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!apb.pready && lat < 200);
    rd  = apb.prdata;
    err = apb.pslverr;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic do_xfer(input bit wr, input logic [15:0] addr, input logic [15:0] wd);
    logic [15:0] rd;
    bit err;
    int lat, falls0, exp_lat;
    bit legal;
    legal  = !addr[0] && !addr[15];
    falls0 = cs_falls;
    apb_xfer(wr, addr, wd, rd, err, lat);
    if (!legal) begin
      check("err_latency", lat, 1);
      check("err_pslverr", err, 1);
      check("err_prdata", rd, 0);
      check("err_no_cs", cs_falls, falls0);
    end else begin
      exp_lat = 2 + 2 * CLK_DIV * (wr ? 12 : 12 + READ_DUMMY) + CLK_DIV;
      check(wr ? "wr_latency" : "rd_latency", lat, exp_lat);
      check("ok_pslverr", err, 0);
      check("sck_cycles", nib_q.size(), wr ? 12 : 12 + READ_DUMMY);
      check("cmd_nibbles", nib_pack(0, 8), {(wr ? 8'h41 : 8'h40), 8'h00, addr});
      if (wr) begin
        check("wdata_nibbles", nib_pack(8, 4), {wd[7:0], wd[15:8]});
        ref_mem[addr] = wd;
        check("dev_written", dev_word(addr), ref_word(addr));
      end else begin
        check("rd_prdata", rd, ref_word(addr));
      end
      exp_cnt++;
    end
  endtask

  initial begin
    bit wr;
    logic [15:0] addr, wd;
    int seen;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", qspi_cs_n, 1);
    check("rst_sck", qspi_sck, 0);
    check("rst_pready", apb.pready, 0);
    check("rst_pslverr", apb.pslverr, 0);
    check("rst_prdata", apb.prdata, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_xfer(1'b1, 16'h0124, 16'hBEEF);
    check("wr_bus_stream", nib_pack(0, 12), 64'h4100_0124_EFBE);
    repeat (3) @(posedge clk);
    #1;

    dev_mem[16'h0010] = 16'h1234;
    ref_mem[16'h0010] = 16'h1234;
    do_xfer(1'b0, 16'h0010, 16'h0000);
    check("rd_device_bytes", nib_pack(12, 4), 16'h3412);

    do_xfer(1'b0, 16'h0011, 16'h0000);
    do_xfer(1'b1, 16'h8000, 16'h5555);

    do_xfer(1'b1, 16'h0200, 16'($urandom));
    do_xfer(1'b1, 16'h0202, 16'($urandom));

    // master abandons the access mid-transfer and scribbles on the bus
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = 16'h0300; apb.pwdata = 16'hCAFE;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.paddr = 16'h0302; apb.pwdata = 16'h1111;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (apb.pready) seen = 1;
    end
    check("drop_pready", seen, 1);
    check("drop_data", dev_word(16'h0300), 16'hCAFE);
    check("drop_addr_ignored", dev_mem.exists(16'h0302), 0);
    ref_mem[16'h0300] = 16'hCAFE;
    exp_cnt++;
    repeat (3) @(posedge clk);
    #1;

    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        addr = 16'($urandom);
        if (!addr[0] && !addr[15]) addr[0] = 1'b1;
      end else begin
        addr = 16'($urandom_range(0, 15) * 2);
      end
      do_xfer(wr, addr, wd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // reset lands in the dummy phase of a read
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 16'h0010;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", qspi_cs_n, 1);
    check("midrst_sck", qspi_sck, 0);
    apb.psel = 1'b0; apb.penable = 1'b0;
    exp_cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_no_pready", apb.pready, 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("postrst_no_pready", apb.pready, 0);
    end
    do_xfer(1'b0, 16'h0010, 16'h0000);

`ifdef QSPI_HOST_XFER_COUNT_EN
    check("xfer_count", xfer_count, exp_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
